// File: rtl/writeback_trap_if.sv
// Memory-stage to writeback handshake bundle: one retiring instruction plus its side effects.
interface writeback_trap_if;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc_in;
  logic [31:0] next_pc_in;
  logic        exception_in;
  logic [3:0]  exc_cause_in;
  logic        mret_in;
  logic        wfi_in;
  logic        csr_we_in;
  logic [11:0] csr_addr_in;
  logic [31:0] csr_data_in;
  logic        rd_we_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_data_in;

  modport master (
    output valid_in, pc_in, next_pc_in, exception_in, exc_cause_in, mret_in, wfi_in,
           csr_we_in, csr_addr_in, csr_data_in, rd_we_in, rd_addr_in, rd_data_in,
    input  ready_out
  );

  modport slave (
    input  valid_in, pc_in, next_pc_in, exception_in, exc_cause_in, mret_in, wfi_in,
           csr_we_in, csr_addr_in, csr_data_in, rd_we_in, rd_addr_in, rd_data_in,
    output ready_out
  );
endinterface

// File: rtl/writeback_trap.sv
// Final pipeline stage: retires instructions and arbitrates interrupts, exceptions, mret and wfi
// into registered csr/regfile writes plus a fetch redirect and a timed pipeline flush.
module writeback_trap #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  writeback_trap_if.slave   mem,
  input  logic              eip,
  input  logic              sip,
  input  logic              tip,
  input  logic [31:0]       trap_vector,
  input  logic [31:0]       mret_vector,
  output logic              retired,
  output logic              traped,
  output logic              mret,
  output logic              interupt,
  output logic [31:0]       ecp,
  output logic [3:0]        trap_cause,
  output logic              write_enable,
  output logic [11:0]       write_address,
  output logic [31:0]       write_data,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_data,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              flush
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, FLUSH, WFI} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      wfi_pc_reg, wfi_pc_next;

  logic        retired_next, traped_next, mret_next, interupt_next;
  logic [31:0] ecp_next;
  logic [3:0]  trap_cause_next;
  logic        write_enable_next;
  logic [11:0] write_address_next;
  logic [31:0] write_data_next;
  logic        reg_we_next;
  logic [4:0]  reg_addr_next;
  logic [31:0] reg_data_next;
  logic        redirect_next;
  logic [31:0] redirect_pc_next;
  logic        flush_next;

  logic        irq;
  logic [3:0]  irq_cause;
  logic        accept;
  logic        take_trap;
  logic        take_irq;
  logic [31:0] trap_pc;
  logic [3:0]  trap_code;
  logic        enter_flush;

  assign irq           = eip | sip | tip;
  assign irq_cause     = eip ? 4'd11 : (sip ? 4'd3 : 4'd7);
  assign mem.ready_out = (state_reg != WFI);
  assign accept        = mem.valid_in && mem.ready_out && (state_reg == RUN);

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    wfi_pc_next        = wfi_pc_reg;
    retired_next       = 1'b0;
    traped_next        = 1'b0;
    mret_next          = 1'b0;
    interupt_next      = 1'b0;
    write_enable_next  = 1'b0;
    reg_we_next        = 1'b0;
    redirect_next      = 1'b0;
    flush_next         = 1'b0;
    ecp_next           = ecp;
    trap_cause_next    = trap_cause;
    write_address_next = write_address;
    write_data_next    = write_data;
    reg_addr_next      = reg_addr;
    reg_data_next      = reg_data;
    redirect_pc_next   = redirect_pc;
    take_trap          = 1'b0;
    take_irq           = 1'b0;
    trap_pc            = mem.pc_in;
    trap_code          = mem.exc_cause_in;
    enter_flush        = 1'b0;

    case (state_reg)
      RUN: begin
        if (accept) begin
          if (irq) begin
            take_trap = 1'b1;
            take_irq  = 1'b1;
            trap_code = irq_cause;
          end else if (mem.exception_in) begin
            take_trap = 1'b1;
          end else if (mem.mret_in) begin
            mret_next        = 1'b1;
            retired_next     = 1'b1;
            redirect_next    = 1'b1;
            redirect_pc_next = mret_vector;
            enter_flush      = 1'b1;
          end else if (mem.wfi_in) begin
            retired_next = 1'b1;
            wfi_pc_next  = mem.next_pc_in;
            state_next   = WFI;
          end else begin
            retired_next      = 1'b1;
            reg_we_next       = mem.rd_we_in && (mem.rd_addr_in != 5'd0);
            write_enable_next = mem.csr_we_in;
            if (reg_we_next) begin
              reg_addr_next = mem.rd_addr_in;
              reg_data_next = mem.rd_data_in;
            end
            if (mem.csr_we_in) begin
              write_address_next = mem.csr_addr_in;
              write_data_next    = mem.csr_data_in;
            end
          end
        end
      end
      FLUSH: begin
        // Anything presented here is drained and dropped; interrupts wait for RUN.
        if (cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          cnt_next   = cnt_reg - 1'b1;
          flush_next = 1'b1;
        end
      end
      WFI: begin
        if (irq) begin
          take_trap = 1'b1;
          take_irq  = 1'b1;
          trap_pc   = wfi_pc_reg;
          trap_code = irq_cause;
        end
      end
      default: state_next = RUN;
    endcase

    if (take_trap) begin
      traped_next      = 1'b1;
      interupt_next    = take_irq;
      ecp_next         = trap_pc;
      trap_cause_next  = trap_code;
      redirect_next    = 1'b1;
      redirect_pc_next = trap_vector;
      enter_flush      = 1'b1;
    end

    // Flush rises together with the registered redirect and counts down from here.
    if (enter_flush) begin
      state_next = FLUSH;
      cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
      flush_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= RUN;
      cnt_reg       <= '0;
      wfi_pc_reg    <= '0;
      retired       <= 1'b0;
      traped        <= 1'b0;
      mret          <= 1'b0;
      interupt      <= 1'b0;
      ecp           <= '0;
      trap_cause    <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      reg_we        <= 1'b0;
      reg_addr      <= '0;
      reg_data      <= '0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      flush         <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wfi_pc_reg    <= wfi_pc_next;
      retired       <= retired_next;
      traped        <= traped_next;
      mret          <= mret_next;
      interupt      <= interupt_next;
      ecp           <= ecp_next;
      trap_cause    <= trap_cause_next;
      write_enable  <= write_enable_next;
      write_address <= write_address_next;
      write_data    <= write_data_next;
      reg_we        <= reg_we_next;
      reg_addr      <= reg_addr_next;
      reg_data      <= reg_data_next;
      redirect      <= redirect_next;
      redirect_pc   <= redirect_pc_next;
      flush         <= flush_next;
    end
  end

endmodule

// File: tb/tb_writeback_trap.sv
// Directed scoreboard bench for writeback_trap: expected outputs are queued as each cycle's
// stimulus is driven and compared one cycle later.
module tb_writeback_trap;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  writeback_trap_if mem ();

  logic        eip, sip, tip;
  logic [31:0] trap_vector, mret_vector;
  logic        retired, traped, mret, interupt;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        write_enable;
  logic [11:0] write_address;
  logic [31:0] write_data;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  writeback_trap #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .mem(mem),
    .eip(eip), .sip(sip), .tip(tip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .retired(retired), .traped(traped), .mret(mret), .interupt(interupt),
    .ecp(ecp), .trap_cause(trap_cause),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  typedef struct {
    logic        retired, traped, mret, interupt, redirect, reg_we, write_enable, flush;
    logic [31:0] ecp, redirect_pc, reg_data, write_data;
    logic [3:0]  trap_cause;
    logic [4:0]  reg_addr;
    logic [11:0] write_address;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  exp_t e;
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t idle();
    exp_t r = hold;
    r.retired = 0; r.traped = 0; r.mret = 0; r.interupt = 0;
    r.redirect = 0; r.reg_we = 0; r.write_enable = 0; r.flush = 0;
    return r;
  endfunction

  function automatic exp_t zero_exp();
    exp_t r;
    r.retired = 0; r.traped = 0; r.mret = 0; r.interupt = 0;
    r.redirect = 0; r.reg_we = 0; r.write_enable = 0; r.flush = 0;
    r.ecp = '0; r.redirect_pc = '0; r.reg_data = '0; r.write_data = '0;
    r.trap_cause = '0; r.reg_addr = '0; r.write_address = '0;
    return r;
  endfunction

  task automatic push(input exp_t x);
    sb.push_back(x);
    hold = x;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, ".retired"},       retired,       x.retired);
      chk({tag, ".traped"},        traped,        x.traped);
      chk({tag, ".mret"},          mret,          x.mret);
      chk({tag, ".interupt"},      interupt,      x.interupt);
      chk({tag, ".redirect"},      redirect,      x.redirect);
      chk({tag, ".reg_we"},        reg_we,        x.reg_we);
      chk({tag, ".write_enable"},  write_enable,  x.write_enable);
      chk({tag, ".flush"},         flush,         x.flush);
      chk({tag, ".ecp"},           ecp,           x.ecp);
      chk({tag, ".redirect_pc"},   redirect_pc,   x.redirect_pc);
      chk({tag, ".reg_data"},      reg_data,      x.reg_data);
      chk({tag, ".write_data"},    write_data,    x.write_data);
      chk({tag, ".trap_cause"},    trap_cause,    x.trap_cause);
      chk({tag, ".reg_addr"},      reg_addr,      x.reg_addr);
      chk({tag, ".write_address"}, write_address, x.write_address);
      $display("txn %-12s retired=%0d traped=%0d mret=%0d int=%0d cause=%0d ecp=%08h redir=%0d rpc=%08h flush=%0d reg_we=%0d x%0d=%08h",
               tag, retired, traped, mret, interupt, trap_cause, ecp, redirect, redirect_pc, flush,
               reg_we, reg_addr, reg_data);
    end
  endtask

  task automatic cycle(input string tag, input exp_t x);
    push(x);
    step();
    check_out(tag);
  endtask

  task automatic clear_instr();
    mem.valid_in = 0; mem.pc_in = '0; mem.next_pc_in = '0;
    mem.exception_in = 0; mem.exc_cause_in = '0; mem.mret_in = 0; mem.wfi_in = 0;
    mem.csr_we_in = 0; mem.csr_addr_in = '0; mem.csr_data_in = '0;
    mem.rd_we_in = 0; mem.rd_addr_in = '0; mem.rd_data_in = '0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic exc, input logic [3:0] cause,
                           input logic is_mret, input logic is_wfi,
                           input logic rdwe, input logic [4:0] rd, input logic [31:0] rdd,
                           input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
    mem.valid_in = 1; mem.pc_in = pc; mem.next_pc_in = pc + 32'd4;
    mem.exception_in = exc; mem.exc_cause_in = cause; mem.mret_in = is_mret; mem.wfi_in = is_wfi;
    mem.rd_we_in = rdwe; mem.rd_addr_in = rd; mem.rd_data_in = rdd;
    mem.csr_we_in = cwe; mem.csr_addr_in = ca; mem.csr_data_in = cd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_instr();
    eip = 0; sip = 0; tip = 0;
    trap_vector = 32'h80; mret_vector = 32'h440;
    hold = zero_exp();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push(zero_exp());
    check_out("reset");
    chk("reset.ready_out", mem.ready_out, 1'b1);
    reset_n = 1;

    // Normal retire with rd and csr write
    set_instr(32'h100, 0, 4'd0, 0, 0, 1, 5'd5, 32'h1234, 1, 12'h340, 32'hdead);
    e = idle(); e.retired = 1; e.reg_we = 1; e.reg_addr = 5; e.reg_data = 32'h1234;
    e.write_enable = 1; e.write_address = 12'h340; e.write_data = 32'hdead;
    cycle("normal", e);
    clear_instr();
    e = idle();
    cycle("idle", e);

    // Write to x0 is dropped
    set_instr(32'h104, 0, 4'd0, 0, 0, 1, 5'd0, 32'h55, 0, 12'h0, 32'h0);
    e = idle(); e.retired = 1;
    cycle("x0", e);

    // Exception suppresses writes, redirects, flushes two cycles
    set_instr(32'h200, 1, 4'd2, 0, 0, 1, 5'd7, 32'h77, 1, 12'h341, 32'h99);
    e = idle(); e.traped = 1; e.ecp = 32'h200; e.trap_cause = 4'd2;
    e.redirect = 1; e.redirect_pc = 32'h80; e.flush = 1;
    cycle("exc", e);
    set_instr(32'h204, 0, 4'd0, 0, 0, 1, 5'd6, 32'h66, 0, 12'h0, 32'h0);
    chk("exc.ready_out", mem.ready_out, 1'b1);
    e = idle(); e.flush = 1;
    cycle("exc.drain1", e);
    e = idle();
    cycle("exc.drain2", e);
    e = idle(); e.retired = 1; e.reg_we = 1; e.reg_addr = 6; e.reg_data = 32'h66;
    cycle("exc.after", e);
    clear_instr();

    // eip+tip beat an exception: cause 11
    eip = 1; tip = 1;
    set_instr(32'h300, 1, 4'd2, 0, 0, 0, 5'd0, 32'h0, 0, 12'h0, 32'h0);
    e = idle(); e.traped = 1; e.interupt = 1; e.ecp = 32'h300; e.trap_cause = 4'd11;
    e.redirect = 1; e.redirect_pc = 32'h80; e.flush = 1;
    cycle("irq.eip", e);
    // sip+tip held through flush: not taken there, waits with no valid instr
    eip = 0; sip = 1;
    set_instr(32'h304, 0, 4'd0, 0, 0, 1, 5'd8, 32'h88, 0, 12'h0, 32'h0);
    e = idle(); e.flush = 1;
    cycle("irq.drain1", e);
    e = idle();
    clear_instr();
    cycle("irq.drain2", e);
    e = idle();
    cycle("irq.wait", e);
    set_instr(32'h310, 0, 4'd0, 0, 0, 1, 5'd8, 32'h88, 0, 12'h0, 32'h0);
    e = idle(); e.traped = 1; e.interupt = 1; e.ecp = 32'h310; e.trap_cause = 4'd3;
    e.redirect = 1; e.redirect_pc = 32'h80; e.flush = 1;
    cycle("irq.sip", e);
    sip = 0; tip = 0;
    clear_instr();
    e = idle(); e.flush = 1;
    cycle("irq.drain3", e);
    e = idle();
    cycle("irq.drain4", e);

    // mret
    set_instr(32'h400, 0, 4'd0, 1, 0, 0, 5'd0, 32'h0, 0, 12'h0, 32'h0);
    e = idle(); e.mret = 1; e.retired = 1; e.redirect = 1; e.redirect_pc = 32'h440; e.flush = 1;
    cycle("mret", e);
    clear_instr();
    e = idle(); e.flush = 1;
    cycle("mret.drain1", e);
    e = idle();
    cycle("mret.drain2", e);

    // wfi: stall 10 cycles with an instr waiting, then timer interrupt
    set_instr(32'h500, 0, 4'd0, 0, 1, 0, 5'd0, 32'h0, 0, 12'h0, 32'h0);
    e = idle(); e.retired = 1;
    cycle("wfi", e);
    set_instr(32'h600, 0, 4'd0, 0, 0, 1, 5'd9, 32'h9, 0, 12'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("wfi.ready_out", mem.ready_out, 1'b0);
      e = idle();
      cycle("wfi.stall", e);
    end
    tip = 1;
    e = idle(); e.traped = 1; e.interupt = 1; e.ecp = 32'h504; e.trap_cause = 4'd7;
    e.redirect = 1; e.redirect_pc = 32'h80; e.flush = 1;
    cycle("wfi.tip", e);
    tip = 0;
    clear_instr();
    chk("wfi.ready_after", mem.ready_out, 1'b1);
    e = idle(); e.flush = 1;
    cycle("wfi.drain1", e);
    e = idle();
    cycle("wfi.drain2", e);

    // Reset in the middle of a flush
    set_instr(32'h700, 1, 4'd5, 0, 0, 0, 5'd0, 32'h0, 0, 12'h0, 32'h0);
    e = idle(); e.traped = 1; e.ecp = 32'h700; e.trap_cause = 4'd5;
    e.redirect = 1; e.redirect_pc = 32'h80; e.flush = 1;
    cycle("exc2", e);
    clear_instr();
    reset_n = 0;
    #1;
    push(zero_exp());
    check_out("rst_flush");
    chk("rst_flush.ready_out", mem.ready_out, 1'b1);
    step();
    reset_n = 1;
    set_instr(32'h800, 0, 4'd0, 0, 0, 1, 5'd9, 32'h9999, 0, 12'h0, 32'h0);
    e = idle(); e.retired = 1; e.reg_we = 1; e.reg_addr = 9; e.reg_data = 32'h9999;
    cycle("post_rst", e);
    clear_instr();

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_left: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
